attn_ram_reader: RTL

ATTN_RAM_READER -- requirements
Module: attn_ram_reader

---
 rtl/attn_ram_reader.sv | 98 +++++++++
 1 files changed

// File: rtl/attn_ram_reader.sv
// attn_ram_reader: streams one attention RAM bank per request through a 2-entry skid FIFO
module attn_ram_reader #(
    parameter int DATA_W = 20,
    parameter int ADDR_W = 12,
    parameter int DEPTH  = 4096
) (
    input  logic              s_clk,
    input  logic              s_rst,
    input  logic              i_AttnRAM_Empty,
    output logic [ADDR_W-1:0] o_AttnRam_rd_addr,
    input  logic [DATA_W-1:0] i_AttnRAM_data,
    output logic              o_AttnRam_Done,
    output logic [DATA_W-1:0] o_Attn_data,
    output logic              o_Attn_valid,
    input  logic              i_Attn_ready,
    output logic              o_Attn_last
);
    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    state_t state, stateNext;
    logic [ADDR_W-1:0] rdAddr, rdAddrNext;
    logic inFlight, inFlightLast, issue, pop, push, atEnd;
    logic [DATA_W-1:0] fifoData [2];
    logic [1:0] fifoLast, count;
    logic [2:0] occ;
    logic wrPtr, rdPtr;
    assign pop = o_Attn_valid & i_Attn_ready;
    assign push = inFlight;
    assign atEnd = rdAddr == LAST_ADDR;
    // occupancy counts the head being popped this cycle as already gone so ready-high streaming sustains one beat per cycle
    assign occ = {1'b0, count} - {2'b0, pop} + {2'b0, inFlight};
    assign o_AttnRam_rd_addr = rdAddr;
    assign o_Attn_valid = count != 2'd0;
    assign o_Attn_data = fifoData[rdPtr];
    assign o_Attn_last = o_Attn_valid & fifoLast[rdPtr];
    // next-state, read issue and address sequencing
    always_comb begin
        stateNext = state;
        rdAddrNext = rdAddr;
        issue = 1'b0;
        o_AttnRam_Done = 1'b0;
        case (state)
            IDLE: begin
                if (!i_AttnRAM_Empty) begin
                    stateNext = READ;
                    rdAddrNext = '0;
                end
            end
            READ: begin
                issue = occ < 3'd2;
                if (issue) begin
                    if (atEnd) stateNext = DRAIN;
                    else rdAddrNext = rdAddr + 1'b1;
                end
            end
            DRAIN: stateNext = (count == 2'd0 && !inFlight) ? DONE : DRAIN;
            DONE: begin
                o_AttnRam_Done = 1'b1;
                stateNext = IDLE;
                rdAddrNext = '0;
            end
            default: stateNext = IDLE;
        endcase
    end
    // state, address and in-flight read tracking
    always_ff @(posedge s_clk or posedge s_rst) begin
        if (s_rst) begin
            state <= IDLE;
            rdAddr <= '0;
            inFlight <= 1'b0;
            inFlightLast <= 1'b0;
        end else begin
            state <= stateNext;
            rdAddr <= rdAddrNext;
            inFlight <= issue;
            inFlightLast <= issue & atEnd;
        end
    end
    // 2-entry FIFO: unconditional capture of the returning read, pop on handshake
    always_ff @(posedge s_clk or posedge s_rst) begin
        if (s_rst) begin
            fifoData[0] <= '0;
            fifoData[1] <= '0;
            fifoLast <= '0;
            wrPtr <= 1'b0;
            rdPtr <= 1'b0;
            count <= '0;
        end else begin
            if (push) begin
                fifoData[wrPtr] <= i_AttnRAM_data;
                fifoLast[wrPtr] <= inFlightLast;
                wrPtr <= ~wrPtr;
            end
            if (pop) rdPtr <= ~rdPtr;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end
endmodule
